// File: rtl/MD_pkg.sv
// Shared types, widths and timing defaults for the MD motion-update phase controller.
package MD_pkg;

   localparam int unsigned PARTICLE_ID_WIDTH        = 8;
   localparam int unsigned MU_NUM_CELLS_DEFAULT     = 8;
   localparam int unsigned MU_QUIET_CYCLES_DEFAULT  = 16;
   localparam int unsigned MU_TIMEOUT_WIDTH_DEFAULT = 20;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4,
      ERROR = 3'd5
   } mu_phase_state_e;

endpackage

// File: rtl/mu_cell_read_tracker.sv
// Per-cell read progress: saturating read counter against the count latched at phase start.
module mu_cell_read_tracker
   import MD_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         rd_en,
   input  logic [PARTICLE_ID_WIDTH-1:0] count,
   output logic                         complete_c
);

   logic [PARTICLE_ID_WIDTH-1:0] limit;
   logic [PARTICLE_ID_WIDTH-1:0] rd_cnt;

   // A zero limit reads as complete straight away; strobes past the limit are dropped.
   assign complete_c = (rd_cnt == limit);

   always_ff @(posedge clk) begin
      if (rst) begin
         limit  <= '0;
         rd_cnt <= '0;
      end else if (start) begin
         limit  <= count;
         rd_cnt <= '0;
      end else if (rd_en && !complete_c) begin
         rd_cnt <= rd_cnt + PARTICLE_ID_WIDTH'(1);
      end
   end

endmodule

// File: rtl/mu_phase_controller.sv
// Sequences one motion-update phase on the MU ring: start, read, drain to quiet, then check
// that every expected particle was written back.
module mu_phase_controller
   import MD_pkg::*;
#(
   parameter int unsigned NUM_CELLS     = MU_NUM_CELLS_DEFAULT,
   parameter int unsigned QUIET_CYCLES  = MU_QUIET_CYCLES_DEFAULT,
   parameter int unsigned TIMEOUT_WIDTH = MU_TIMEOUT_WIDTH_DEFAULT
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic                                           i_iter_start,
   input  logic [NUM_CELLS*PARTICLE_ID_WIDTH-1:0]         i_num_particles,
   input  logic [NUM_CELLS-1:0]                           i_rd_en,
   input  logic [NUM_CELLS-1:0]                           i_wr_valid,
   input  logic [NUM_CELLS-1:0]                           i_fwd_valid,
   input  logic [NUM_CELLS-1:0]                           i_buf_empty,
   input  logic [NUM_CELLS-1:0]                           i_buf_full,
   output logic [NUM_CELLS-1:0]                           o_MU_start,
   output logic                                           o_stall,
   output logic                                           o_busy,
   output logic                                           o_done,
   output logic                                           o_error,
   output logic [PARTICLE_ID_WIDTH+$clog2(NUM_CELLS)-1:0] o_wr_total
);

   localparam int unsigned TOTAL_W = PARTICLE_ID_WIDTH + $clog2(NUM_CELLS);
   localparam int unsigned QUIET_W = $clog2(QUIET_CYCLES + 1) + 1;
   localparam int unsigned POP_W   = $clog2(NUM_CELLS + 1);
   // One short of all-ones, so the count lands on all-ones the same edge ERROR is entered.
   localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = ~TIMEOUT_WIDTH'(1);

   mu_phase_state_e state, state_nxt;

   logic [NUM_CELLS-1:0]     read_done_c;
   logic [QUIET_W-1:0]       quiet_cnt;
   logic [TIMEOUT_WIDTH-1:0] wd_cnt;
   logic [TOTAL_W-1:0]       exp_total;
   logic [TOTAL_W-1:0]       sum_c;
   logic [POP_W-1:0]         pop_c;
   logic                     all_read_c, ring_idle_c, timeout_c, quiet_hit_c, run_c, in_read_c;
   logic [NUM_CELLS-1:0]     mu_start_nxt;
   logic                     stall_nxt, busy_nxt, done_nxt, error_nxt;

   assign in_read_c   = (state == READ);
   assign run_c       = (state == READ) || (state == DRAIN);
   assign all_read_c  = &read_done_c;
   assign ring_idle_c = (&i_buf_empty) && !(|i_fwd_valid) && !(|i_wr_valid);
   assign timeout_c   = (wd_cnt == WD_LAST);
   assign quiet_hit_c = (quiet_cnt == QUIET_W'(QUIET_CYCLES));

   for (genvar k = 0; k < NUM_CELLS; k++) begin : g_cell
      mu_cell_read_tracker u_tracker (
         .clk        (clk),
         .rst        (rst),
         .start      (state == START),
         .rd_en      (i_rd_en[k] && in_read_c),
         .count      (i_num_particles[k*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH]),
         .complete_c (read_done_c[k])
      );
   end

   // Write-back popcount and expected total across all cells.
   always_comb begin
      pop_c = '0;
      sum_c = '0;
      for (int unsigned k = 0; k < NUM_CELLS; k++) begin
         pop_c = pop_c + POP_W'(i_wr_valid[k]);
         sum_c = sum_c + TOTAL_W'(i_num_particles[k*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH]);
      end
   end

   // Next state and next registered outputs.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_iter_start) state_nxt = START;
         START:   state_nxt = READ;
         READ: begin
            if (timeout_c)       state_nxt = ERROR;
            else if (all_read_c) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (timeout_c)        state_nxt = ERROR;
            else if (quiet_hit_c) state_nxt = (o_wr_total == exp_total) ? DONE : ERROR;
         end
         DONE:    state_nxt = IDLE;
         ERROR:   state_nxt = ERROR;
         default: state_nxt = IDLE;
      endcase

      mu_start_nxt = {NUM_CELLS{state_nxt == START}};
      stall_nxt    = (state_nxt == READ) && (|i_buf_full);
      busy_nxt     = (state_nxt == START) || (state_nxt == READ) || (state_nxt == DRAIN);
      done_nxt     = (state_nxt == DONE);
      error_nxt    = (state_nxt == ERROR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         o_MU_start <= '0;
         o_stall    <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_error    <= 1'b0;
         o_wr_total <= '0;
         exp_total  <= '0;
         quiet_cnt  <= '0;
         wd_cnt     <= '0;
      end else begin
         state      <= state_nxt;
         o_MU_start <= mu_start_nxt;
         o_stall    <= stall_nxt;
         o_busy     <= busy_nxt;
         o_done     <= done_nxt;
         o_error    <= error_nxt;
         if (state == START) begin
            o_wr_total <= '0;
            exp_total  <= sum_c;
            quiet_cnt  <= '0;
            wd_cnt     <= '0;
         end else if (run_c) begin
            o_wr_total <= o_wr_total + TOTAL_W'(pop_c);
            wd_cnt     <= wd_cnt + TIMEOUT_WIDTH'(1);
            if (state == DRAIN)
               quiet_cnt <= ring_idle_c ? quiet_cnt + QUIET_W'(1) : '0;
         end
      end
   end

endmodule

// File: tb/tb_mu_phase_controller.sv
// Directed bench for mu_phase_controller: vector table for the nominal phase plus
// hand-written sequences for quiet restart, count mismatch, watchdog and abort.
module tb_mu_phase_controller;

   localparam int unsigned NC = 8;
   localparam int unsigned PW = MD_pkg::PARTICLE_ID_WIDTH;
   localparam int unsigned TW = PW + $clog2(NC);

   typedef struct {
      logic          rst;
      logic          start;
      logic [NC*PW-1:0] num;
      logic [NC-1:0] rd;
      logic [NC-1:0] wr;
      logic [NC-1:0] fwd;
      logic [NC-1:0] full;
      logic [NC-1:0] e_mu;
      logic          e_stall;
      logic          e_busy;
      logic          e_done;
      logic          e_error;
      logic [TW-1:0] e_total;
   } vec_t;

   logic clk = 1'b0;
   logic rst, rst_wd, iter_start;
   logic [NC*PW-1:0] num;
   logic [NC-1:0] rd_en, wr_valid, fwd_valid, buf_empty, buf_full;
   logic [NC-1:0] mu_start, mu_start_wd;
   logic stall, busy, done, error;
   logic stall_wd, busy_wd, done_wd, error_wd;
   logic [TW-1:0] wr_total, wr_total_wd;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   mu_phase_controller dut (
      .clk(clk), .rst(rst), .i_iter_start(iter_start), .i_num_particles(num),
      .i_rd_en(rd_en), .i_wr_valid(wr_valid), .i_fwd_valid(fwd_valid),
      .i_buf_empty(buf_empty), .i_buf_full(buf_full), .o_MU_start(mu_start),
      .o_stall(stall), .o_busy(busy), .o_done(done), .o_error(error), .o_wr_total(wr_total)
   );

   mu_phase_controller #(.TIMEOUT_WIDTH(6)) dut_wd (
      .clk(clk), .rst(rst_wd), .i_iter_start(iter_start), .i_num_particles(num),
      .i_rd_en(rd_en), .i_wr_valid(wr_valid), .i_fwd_valid(fwd_valid),
      .i_buf_empty(buf_empty), .i_buf_full(buf_full), .o_MU_start(mu_start_wd),
      .o_stall(stall_wd), .o_busy(busy_wd), .o_done(done_wd), .o_error(error_wd),
      .o_wr_total(wr_total_wd)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic s, input logic [NC*PW-1:0] n,
                      input logic [NC-1:0] rd, input logic [NC-1:0] wr,
                      input logic [NC-1:0] fwd, input logic [NC-1:0] full,
                      input logic [NC-1:0] e_mu, input logic e_stall, input logic e_busy,
                      input logic e_done, input logic e_error, input logic [TW-1:0] e_total);
      vec_t v;
      v.rst = r; v.start = s; v.num = n; v.rd = rd; v.wr = wr; v.fwd = fwd; v.full = full;
      v.e_mu = e_mu; v.e_stall = e_stall; v.e_busy = e_busy; v.e_done = e_done;
      v.e_error = e_error; v.e_total = e_total;
      tbl.push_back(v);
   endtask

   task automatic idle_inputs();
      iter_start = 1'b0;
      rd_en      = '0;
      wr_valid   = '0;
      fwd_valid  = '0;
      buf_empty  = '1;
      buf_full   = '0;
   endtask

   initial begin
      logic [NC*PW-1:0] n3;
      int k_done;
      int n_done;
      bit seen_err;

      rst = 1'b1;
      rst_wd = 1'b1;
      num = '0;
      idle_inputs();
      n3 = '0;
      n3[PW-1:0] = PW'(3);

      // Nominal phase: counts {3,0,..}, 3 reads/write-backs, 16 quiet cycles, done.
      add(1, 0, '0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, TW'(0));
      add(1, 0, '0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, TW'(0));
      add(0, 1, n3, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 1, 0, 0, TW'(0));
      add(0, 0, n3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, TW'(0));
      add(0, 0, '0, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, TW'(1));
      add(0, 0, '0, 8'h01, 8'h01, 8'h00, 8'h04, 8'h00, 1, 1, 0, 0, TW'(2));
      add(0, 0, '0, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, TW'(3));
      add(0, 1, '0, 8'h01, 8'h00, 8'h00, 8'h04, 8'h00, 0, 1, 0, 0, TW'(3));
      for (int i = 0; i < 16; i++)
         add(0, 0, '0, 8'h00, 8'h00, 8'h00, (i == 0) ? 8'h04 : 8'h00, 8'h00, 0, 1, 0, 0, TW'(3));
      add(0, 0, '0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, TW'(3));
      add(0, 0, '0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, TW'(3));

      foreach (tbl[i]) begin
         rst        = tbl[i].rst;
         iter_start = tbl[i].start;
         num        = tbl[i].num;
         rd_en      = tbl[i].rd;
         wr_valid   = tbl[i].wr;
         fwd_valid  = tbl[i].fwd;
         buf_full   = tbl[i].full;
         buf_empty  = '1;
         tick();
         chk($sformatf("v%0d mu_start", i), 64'(mu_start), 64'(tbl[i].e_mu));
         chk($sformatf("v%0d stall", i),    64'(stall),    64'(tbl[i].e_stall));
         chk($sformatf("v%0d busy", i),     64'(busy),     64'(tbl[i].e_busy));
         chk($sformatf("v%0d done", i),     64'(done),     64'(tbl[i].e_done));
         chk($sformatf("v%0d error", i),    64'(error),    64'(tbl[i].e_error));
         chk($sformatf("v%0d wr_total", i), 64'(wr_total), 64'(tbl[i].e_total));
      end
      idle_inputs();

      // Quiet restart: fwd_valid at quiet count 15 pushes o_done out by 16 cycles.
      num = '0;
      iter_start = 1'b1;
      tick();
      iter_start = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 15; i++) tick();
      fwd_valid = 8'h01;
      tick();
      fwd_valid = '0;
      k_done = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (done === 1'b1) begin
            k_done = k;
            break;
         end
      end
      chk("quiet_restart done_delay", 64'(k_done), 64'(17));
      chk("quiet_restart wr_total", 64'(wr_total), 64'(0));
      chk("quiet_restart error", 64'(error), 64'(0));
      tick();
      chk("quiet_restart done_one_cycle", 64'(done), 64'(0));

      // Count mismatch: expected 10, only 9 write-backs -> ERROR, never done.
      num = '0;
      num[0*PW +: PW] = PW'(4);
      num[1*PW +: PW] = PW'(3);
      num[2*PW +: PW] = PW'(2);
      num[3*PW +: PW] = PW'(1);
      iter_start = 1'b1;
      tick();
      iter_start = 1'b0;
      tick();
      rd_en = '1;
      wr_valid = 8'h0F; tick();
      wr_valid = 8'h07; tick();
      wr_valid = 8'h03; tick();
      wr_valid = 8'h00; tick();
      rd_en = '0;
      n_done = 0;
      seen_err = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (done === 1'b1) n_done++;
         if (error === 1'b1) begin
            seen_err = 1'b1;
            break;
         end
      end
      chk("mismatch error_seen", 64'(seen_err), 64'(1));
      chk("mismatch done_count", 64'(n_done), 64'(0));
      chk("mismatch wr_total", 64'(wr_total), 64'(9));
      chk("mismatch busy", 64'(busy), 64'(0));
      iter_start = 1'b1;
      tick();
      tick();
      iter_start = 1'b0;
      chk("mismatch error_sticky", 64'(error), 64'(1));
      chk("mismatch start_ignored", 64'(mu_start), 64'(0));
      chk("mismatch wr_total_held", 64'(wr_total), 64'(9));
      rst = 1'b1;
      tick();
      chk("mismatch rst_error", 64'(error), 64'(0));
      chk("mismatch rst_total", 64'(wr_total), 64'(0));

      // Watchdog (6-bit): reads withheld, ERROR 63 cycles after READ entry.
      rst_wd = 1'b0;
      num = '0;
      num[PW-1:0] = PW'(1);
      iter_start = 1'b1;
      tick();
      iter_start = 1'b0;
      chk("wd mu_start", 64'(mu_start_wd), 64'(8'hFF));
      for (int s = 1; s <= 64; s++) begin
         tick();
         if (s == 63) chk("wd error_before", 64'(error_wd), 64'(0));
         if (s == 64) begin
            chk("wd error_at_63", 64'(error_wd), 64'(1));
            chk("wd busy", 64'(busy_wd), 64'(0));
         end
      end
      chk("wd main_held_in_rst", 64'(error), 64'(0));
      rst_wd = 1'b1;
      rst = 1'b0;
      tick();

      // iter_start ignored in READ; rst in DRAIN aborts without done.
      num = '0;
      num[PW-1:0] = PW'(2);
      iter_start = 1'b1;
      tick();
      iter_start = 1'b0;
      tick();
      iter_start = 1'b1;
      tick();
      iter_start = 1'b0;
      chk("abort start_in_read_mu", 64'(mu_start), 64'(0));
      chk("abort start_in_read_busy", 64'(busy), 64'(1));
      rd_en = 8'h01; wr_valid = 8'h01; tick(); tick();
      rd_en = '0; wr_valid = '0; tick();
      buf_full = 8'h04;
      tick(); tick(); tick();
      chk("abort drain_busy", 64'(busy), 64'(1));
      chk("abort drain_stall", 64'(stall), 64'(0));
      chk("abort drain_total", 64'(wr_total), 64'(2));
      buf_full = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort rst_outputs",
          64'({mu_start, stall, busy, done, error, wr_total}), 64'(0));
      n_done = 0;
      for (int k = 0; k < 25; k++) begin
         tick();
         if (done === 1'b1) n_done++;
      end
      chk("abort no_done", 64'(n_done), 64'(0));
      chk("abort idle_busy", 64'(busy), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
